alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Command-driven controller that owns the 4-bit ALU datapath.
- Accepts one instruction at a time over a valid/ready handshake.
- Reads operands from a private 4-entry x 4-bit register file, then drives the ALU opcode, operand and enable lines.
- Waits a fixed ALU latency, writes the ALU result back to the register file and returns it to the requester over a second valid/ready handshake.

Parameters:
- ALU_LATENCY, 1, clock cycles from the ALU sampling its inputs to its output being valid; legal range 1..7.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  global enable; low freezes all state
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_load  input  1  1 = write cmd_imm to rd without using the ALU
- cmd_op  input  3  ALU opcode
- cmd_rd  input  2  destination register index
- cmd_rs  input  2  source register index, used as in_2
- cmd_use_imm  input  1  1 = in_2 comes from cmd_imm instead of reg[rs]
- cmd_imm  input  4  immediate value
- alu_en  output  1  ALU enable
- alu_opcode  output  3  to ALU opcode
- alu_in_1  output  4  to ALU in_1, always reg[rd]
- alu_in_2  output  4  to ALU in_2
- alu_out  input  4  ALU result
- res_valid  output  1  result available
- res_ready  input  1  requester accepts the result
- res_data  output  4  value written to rd

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all regs[0..3]=0.
  - cmd_ready=0 during reset, 1 from the first edge after release.
  - alu_en=0, alu_opcode=0, alu_in_1=0, alu_in_2=0, res_valid=0, res_data=0.
- Reset mid-operation aborts the command. No writeback occurs and no result is presented.
- ena=0: every register holds and alu_en is forced to 0. cmd_ready and res_valid hold their values, but no handshake completes while ena=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready=1. Accept on an edge where cmd_valid & cmd_ready & ena.
  - Latch op, rd, and operand2 = cmd_use_imm ? cmd_imm : reg[rs]. Latch operand1 = reg[rd]; register values are sampled at the accept edge.
  - If cmd_load: reg[rd] <= cmd_imm, res_data <= cmd_imm, go to RESP.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - cmd_ready=0, alu_en=1, and alu_opcode/alu_in_1/alu_in_2 are driven from the latched values.
  - Load the wait counter with ALU_LATENCY-1, go to WAIT.
- WAIT:
  - alu_en=1; operands and opcode are held stable.
  - The counter decrements each cycle. When it reads 0: reg[rd] <= alu_out, res_data <= alu_out, go to RESP.
  - Total WAIT length is ALU_LATENCY cycles.
- RESP:
  - res_valid=1, alu_en=0.
  - res_data is stable until res_ready is sampled high; on that edge res_valid drops and the FSM goes to IDLE.
  - res_ready held low stalls the FSM indefinitely.
- Outside ISSUE/WAIT the ALU outputs hold their last values and alu_en=0.
- Latency, ALU command with ALU_LATENCY=1, accept edge = t0:
  - ISSUE during cycle t0+1; WAIT during cycle t0+2; res_valid high from t0+3.
  - General case: res_valid rises ALU_LATENCY+2 cycles after accept.
- Latency, load command: res_valid rises 1 cycle after accept.
- Back-to-back: a new command is accepted no earlier than the cycle after the res handshake. Throughput is at most one command per (ALU_LATENCY+3) cycles.
- Hazards: rd == rs uses the old reg value for both operands. Writeback is visible to the next accepted command.
- All arithmetic is 4 bits; the ALU result is written unmodified and no flags are kept.

Test Plan:
- Reset and load:
  - Stimulus: rst_n low 3 cycles, release, then load rd=2 imm=4'hA.
  - Required: cmd_ready=1 after release; res_valid=1 exactly 1 cycle after accept with res_data=A; a later read-back shows reg[2]=A.
- ALU issue timing (ALU_LATENCY=1, stub ALU registers in_1 ^ in_2):
  - Stimulus: load r0=5, r1=3, then op=3'b010 rd=0 rs=1.
  - Required: alu_en high for exactly 2 cycles with in_1=5, in_2=3, opcode=2; res_valid at accept+3 with res_data=6; r0=6 afterwards.
- Immediate and rd==rs:
  - Stimulus: op rd=1 rs=1 use_imm=1 imm=F with r1=3.
  - Required: in_1=3, in_2=F; result 3^F=C written to r1.
- Backpressure:
  - Stimulus: hold res_ready=0 for 5 cycles.
  - Required: res_valid and res_data stable, cmd_ready=0 throughout; res_ready=1 -> IDLE next cycle, cmd_ready=1.
- ena freeze:
  - Stimulus: deassert ena for 4 cycles during WAIT with ALU_LATENCY=3.
  - Required: alu_en=0 during the freeze; the counter resumes afterwards; result still correct; res_valid arrives 4 cycles later than nominal.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during WAIT.
  - Required: outputs go to reset values immediately (async); no res_valid; all regs=0.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Command, ALU and response signals of the ALU sequencer.
// The sequencer takes the slave view; the requester plus ALU take the master view.
interface alu_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd;
  logic [1:0] cmd_rs;
  logic       cmd_use_imm;
  logic [3:0] cmd_imm;
  logic       alu_en;
  logic [2:0] alu_opcode;
  logic [3:0] alu_in_1;
  logic [3:0] alu_in_2;
  logic [3:0] alu_out;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_rd, cmd_rs, cmd_use_imm, cmd_imm,
    output cmd_ready,
    output alu_en, alu_opcode, alu_in_1, alu_in_2,
    input  alu_out,
    output res_valid, res_data,
    input  res_ready
  );

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_rd, cmd_rs, cmd_use_imm, cmd_imm,
    input  cmd_ready,
    input  alu_en, alu_opcode, alu_in_1, alu_in_2,
    output alu_out,
    input  res_valid, res_data,
    output res_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequencer owning a 4x4-bit register file: accepts a command, drives the ALU
// for one ISSUE cycle plus ALU_LATENCY WAIT cycles, writes back and returns the result.
module alu_sequencer #(
  parameter int ALU_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  alu_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] WAIT_INIT = 3'(ALU_LATENCY - 1);

  state_t     state_q;
  logic [3:0] regs_q [4];
  logic [1:0] rd_q;
  logic [2:0] cnt_q;
  logic       cmd_ready_q;
  logic       alu_en_q;
  logic       res_valid_q;
  logic [2:0] alu_opcode_q;
  logic [3:0] alu_in_1_q;
  logic [3:0] alu_in_2_q;
  logic [3:0] res_data_q;
  logic [3:0] in_2_d;
  logic       accept_d;

  assign in_2_d   = bus.cmd_use_imm ? bus.cmd_imm : regs_q[bus.cmd_rs];
  assign accept_d = bus.cmd_valid & cmd_ready_q;

  assign bus.cmd_ready  = cmd_ready_q;
  // A frozen sequencer must not let the ALU advance.
  assign bus.alu_en     = alu_en_q & ena;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_in_1   = alu_in_1_q;
  assign bus.alu_in_2   = alu_in_2_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      for (int i = 0; i < 4; i++) regs_q[i] <= 4'd0;
      rd_q         <= 2'd0;
      cnt_q        <= 3'd0;
      cmd_ready_q  <= 1'b0;
      alu_en_q     <= 1'b0;
      res_valid_q  <= 1'b0;
      alu_opcode_q <= 3'd0;
      alu_in_1_q   <= 4'd0;
      alu_in_2_q   <= 4'd0;
      res_data_q   <= 4'd0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept_d) begin
            cmd_ready_q <= 1'b0;
            rd_q        <= bus.cmd_rd;
            if (bus.cmd_load) begin
              regs_q[bus.cmd_rd] <= bus.cmd_imm;
              res_data_q         <= bus.cmd_imm;
              res_valid_q        <= 1'b1;
              state_q            <= RESP;
            end else begin
              // Operands are snapshotted here, so rd == rs sees the old value twice.
              alu_opcode_q <= bus.cmd_op;
              alu_in_1_q   <= regs_q[bus.cmd_rd];
              alu_in_2_q   <= in_2_d;
              alu_en_q     <= 1'b1;
              state_q      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt_q   <= WAIT_INIT;
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == 3'd0) begin
            regs_q[rd_q] <= bus.alu_out;
            res_data_q   <= bus.alu_out;
            alu_en_q     <= 1'b0;
            res_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RESP: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (ALU latency 1 and 3) share one stimulus
// stream and are checked every cycle against a transaction-level reference model.
module tb_alu_sequencer;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic cmd_valid = 1'b0, cmd_load = 1'b0, cmd_use_imm = 1'b0, res_ready = 1'b1;
  logic [2:0] cmd_op = 3'd0;
  logic [1:0] cmd_rd = 2'd0, cmd_rs = 2'd0;
  logic [3:0] cmd_imm = 4'd0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_sequencer_if bus1 ();
  alu_sequencer_if bus3 ();

  alu_sequencer #(.ALU_LATENCY(LAT0)) dut1 (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus1));
  alu_sequencer #(.ALU_LATENCY(LAT1)) dut3 (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus3));

  assign bus1.cmd_valid = cmd_valid;   assign bus3.cmd_valid = cmd_valid;
  assign bus1.cmd_load = cmd_load;     assign bus3.cmd_load = cmd_load;
  assign bus1.cmd_op = cmd_op;         assign bus3.cmd_op = cmd_op;
  assign bus1.cmd_rd = cmd_rd;         assign bus3.cmd_rd = cmd_rd;
  assign bus1.cmd_rs = cmd_rs;         assign bus3.cmd_rs = cmd_rs;
  assign bus1.cmd_use_imm = cmd_use_imm; assign bus3.cmd_use_imm = cmd_use_imm;
  assign bus1.cmd_imm = cmd_imm;       assign bus3.cmd_imm = cmd_imm;
  assign bus1.res_ready = res_ready;   assign bus3.res_ready = res_ready;

  function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a ^ b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a;
      3'd6: return b;
      default: return ~a;
    endcase
  endfunction

  // Stub ALUs: a pipeline whose depth equals the instance's latency
  logic [3:0] p1 = 4'd0;
  logic [3:0] p3 [3] = '{4'd0, 4'd0, 4'd0};
  always @(posedge clk) p1 <= alu_f(bus1.alu_opcode, bus1.alu_in_1, bus1.alu_in_2);
  always @(posedge clk) begin
    p3[0] <= alu_f(bus3.alu_opcode, bus3.alu_in_1, bus3.alu_in_2);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus1.alu_out = p1;
  assign bus3.alu_out = p3[2];

  logic       o_rdy [2], o_rv [2], o_en [2];
  logic [2:0] o_op [2];
  logic [3:0] o_in1 [2], o_in2 [2], o_dat [2];
  assign o_rdy[0] = bus1.cmd_ready;  assign o_rdy[1] = bus3.cmd_ready;
  assign o_rv[0]  = bus1.res_valid;  assign o_rv[1]  = bus3.res_valid;
  assign o_en[0]  = bus1.alu_en;     assign o_en[1]  = bus3.alu_en;
  assign o_op[0]  = bus1.alu_opcode; assign o_op[1]  = bus3.alu_opcode;
  assign o_in1[0] = bus1.alu_in_1;   assign o_in1[1] = bus3.alu_in_1;
  assign o_in2[0] = bus1.alu_in_2;   assign o_in2[1] = bus3.alu_in_2;
  assign o_dat[0] = bus1.res_data;   assign o_dat[1] = bus3.res_data;

  // Reference model: a command is a transaction; m_n counts enabled edges since accept.
  // ALU commands drive the ALU for m_n = 0..LAT and respond from m_n = LAT+1.
  logic [3:0] mregs [2][4];
  bit         m_rdy [2], m_busy [2], m_load [2];
  int         m_n [2];
  logic [1:0] m_rd [2];
  logic [2:0] m_op [2];
  logic [3:0] m_a [2], m_b [2], m_dat [2];

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_rdy[i] = 0; m_busy[i] = 0; m_load[i] = 0; m_n[i] = 0; m_rd[i] = 2'd0;
      m_op[i] = 3'd0; m_a[i] = 4'd0; m_b[i] = 4'd0; m_dat[i] = 4'd0;
      for (int r = 0; r < 4; r++) mregs[i][r] = 4'd0;
    end
  endtask

  task automatic m_step(input int i);
    bit pre_ready, pre_rv;
    int lat;
    logic [3:0] a, b, r;
    lat = (i == 0) ? LAT0 : LAT1;
    pre_ready = m_rdy[i] && !m_busy[i];
    pre_rv = m_busy[i] && (m_load[i] || m_n[i] >= lat + 1);
    m_rdy[i] = 1;
    if (m_busy[i]) begin
      if (pre_rv) begin
        if (res_ready) m_busy[i] = 0;
      end else begin
        m_n[i]++;
        if (m_n[i] == lat + 1) begin
          r = alu_f(m_op[i], m_a[i], m_b[i]);
          mregs[i][m_rd[i]] = r;
          m_dat[i] = r;
        end
      end
    end else if (pre_ready && cmd_valid) begin
      a = mregs[i][cmd_rd];
      b = cmd_use_imm ? cmd_imm : mregs[i][cmd_rs];
      m_busy[i] = 1; m_n[i] = 0; m_load[i] = cmd_load; m_rd[i] = cmd_rd;
      if (cmd_load) begin
        mregs[i][cmd_rd] = cmd_imm;
        m_dat[i] = cmd_imm;
      end else begin
        m_op[i] = cmd_op; m_a[i] = a; m_b[i] = b;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else if (ena) for (int i = 0; i < 2; i++) m_step(i);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s at %0t: bound expired waiting on DUT", name, $time);
  endtask

  // Per-cycle compare of every output of both instances against the model
  always @(negedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      int lat;
      bit e_rv, e_en;
      lat = (i == 0) ? LAT0 : LAT1;
      e_rv = m_busy[i] && (m_load[i] || m_n[i] >= lat + 1);
      e_en = m_busy[i] && !m_load[i] && m_n[i] <= lat && ena;
      chk($sformatf("i%0d.cmd_ready", i), int'(o_rdy[i]), int'(m_rdy[i] && !m_busy[i]));
      chk($sformatf("i%0d.res_valid", i), int'(o_rv[i]), int'(e_rv));
      chk($sformatf("i%0d.alu_en", i), int'(o_en[i]), int'(e_en));
      chk($sformatf("i%0d.res_data", i), int'(o_dat[i]), int'(m_dat[i]));
      chk($sformatf("i%0d.alu_opcode", i), int'(o_op[i]), int'(m_op[i]));
      chk($sformatf("i%0d.alu_in_1", i), int'(o_in1[i]), int'(m_a[i]));
      chk($sformatf("i%0d.alu_in_2", i), int'(o_in2[i]), int'(m_b[i]));
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clk);
    while (!(bus1.cmd_ready && bus3.cmd_ready) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) timeout_fail("wait_ready");
  endtask

  task automatic run_cmd(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] rs, input logic ui, input logic [3:0] imm,
                         input bit frz, input int hold,
                         output int lat0, output int lat1, output logic [3:0] d0,
                         output logic [3:0] d1, output int en0,
                         output logic [3:0] i1, output logic [3:0] i2);
    int cyc;
    bit done;
    ena = 1'b1;
    res_ready = 1'b1;
    wait_ready();
    cmd_load = ld; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_use_imm = ui; cmd_imm = imm;
    cmd_valid = 1'b1;
    res_ready = (hold == 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1; lat0 = -1; lat1 = -1; en0 = 0; d0 = 4'd0; d1 = 4'd0; i1 = 4'd0; i2 = 4'd0;
    done = 0;
    while (!done) begin
      res_ready = (cyc > hold);
      ena = !(frz && cyc >= 2 && cyc <= 5);
      #1;
      if (bus1.alu_en) en0++;
      if (cyc == 1) begin i1 = bus1.alu_in_1; i2 = bus1.alu_in_2; end
      if (lat0 < 0 && bus1.res_valid) begin lat0 = cyc; d0 = bus1.res_data; end
      if (lat1 < 0 && bus3.res_valid) begin lat1 = cyc; d1 = bus3.res_data; end
      if (lat0 >= 0 && lat1 >= 0 && cyc > hold) done = 1;
      else if (cyc >= 60) begin timeout_fail("run_cmd"); done = 1; end
      else begin @(negedge clk); cyc++; end
    end
    ena = 1'b1;
  endtask

  initial begin
    int l0, l1, e0, rst_cnt;
    logic [3:0] d0, d1, i1, i2;

    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    #1;
    chk("rst.cmd_ready0", int'(bus1.cmd_ready), 0);
    chk("rst.cmd_ready1", int'(bus3.cmd_ready), 0);
    chk("rst.res_valid0", int'(bus1.res_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rel.cmd_ready0", int'(bus1.cmd_ready), 1);
    chk("rel.cmd_ready1", int'(bus3.cmd_ready), 1);

    run_cmd(1'b1, 3'd0, 2'd2, 2'd0, 1'b0, 4'hA, 0, 0, l0, l1, d0, d1, e0, i1, i2);
    chk("load.lat0", l0, 1);
    chk("load.lat1", l1, 1);
    chk("load.data0", int'(d0), 'hA);
    chk("load.data1", int'(d1), 'hA);

    run_cmd(1'b1, 3'd0, 2'd0, 2'd0, 1'b0, 4'h5, 0, 0, l0, l1, d0, d1, e0, i1, i2);
    run_cmd(1'b1, 3'd0, 2'd1, 2'd0, 1'b0, 4'h3, 0, 0, l0, l1, d0, d1, e0, i1, i2);
    run_cmd(1'b0, 3'd2, 2'd0, 2'd1, 1'b0, 4'h0, 0, 0, l0, l1, d0, d1, e0, i1, i2);
    chk("xor.lat0", l0, 3);
    chk("xor.lat1", l1, 5);
    chk("xor.data0", int'(d0), 6);
    chk("xor.data1", int'(d1), 6);
    chk("xor.en_cycles0", e0, 2);
    chk("xor.in_1", int'(i1), 5);
    chk("xor.in_2", int'(i2), 3);

    run_cmd(1'b0, 3'd2, 2'd1, 2'd1, 1'b1, 4'hF, 0, 0, l0, l1, d0, d1, e0, i1, i2);
    chk("imm.data0", int'(d0), 'hC);
    chk("imm.in_1", int'(i1), 3);
    chk("imm.in_2", int'(i2), 'hF);

    run_cmd(1'b0, 3'd5, 2'd2, 2'd0, 1'b0, 4'h0, 0, 0, l0, l1, d0, d1, e0, i1, i2);
    chk("readback.r2", int'(d0), 'hA);

    // Backpressure: res_ready low for 5 cycles of presented result
    run_cmd(1'b1, 3'd0, 2'd3, 2'd0, 1'b0, 4'h7, 0, 5, l0, l1, d0, d1, e0, i1, i2);
    chk("bp.data0", int'(d0), 7);
    @(negedge clk);
    #1;
    chk("bp.cmd_ready0", int'(bus1.cmd_ready), 1);
    chk("bp.cmd_ready1", int'(bus3.cmd_ready), 1);

    // ena freeze of 4 cycles while both instances wait: r0 = 6 + C
    run_cmd(1'b0, 3'd0, 2'd0, 2'd1, 1'b0, 4'h0, 1, 0, l0, l1, d0, d1, e0, i1, i2);
    chk("frz.lat0", l0, 7);
    chk("frz.lat1", l1, 9);
    chk("frz.data0", int'(d0), 2);
    chk("frz.data1", int'(d1), 2);
    chk("frz.en_cycles0", e0, 2);

    // Reset in the middle of a WAIT
    wait_ready();
    cmd_load = 1'b0; cmd_op = 3'd2; cmd_rd = 2'd3; cmd_rs = 2'd0; cmd_use_imm = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.res_valid1", int'(bus3.res_valid), 0);
    chk("mid.alu_en1", int'(bus3.alu_en), 0);
    chk("mid.cmd_ready1", int'(bus3.cmd_ready), 0);
    chk("mid.res_data1", int'(bus3.res_data), 0);
    chk("mid.alu_in_1_1", int'(bus3.alu_in_1), 0);
    chk("mid.alu_opcode1", int'(bus3.alu_opcode), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_cmd(1'b0, 3'd2, 2'd0, 2'd3, 1'b0, 4'h0, 0, 0, l0, l1, d0, d1, e0, i1, i2);
    chk("post.r0^r3", int'(d1), 0);
    run_cmd(1'b0, 3'd5, 2'd2, 2'd0, 1'b0, 4'h0, 0, 0, l0, l1, d0, d1, e0, i1, i2);
    chk("post.r2", int'(d0), 0);

    // Randomized traffic with occasional async resets
    rst_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rst_n == 1'b0) begin
        if (rst_cnt > 0) rst_cnt--;
        else rst_n = 1'b1;
      end else if ($urandom_range(0, 249) == 0) begin
        rst_n = 1'b0;
        rst_cnt = $urandom_range(0, 2);
      end
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_load = ($urandom_range(0, 3) == 0);
      cmd_op = 3'($urandom_range(0, 7));
      cmd_rd = 2'($urandom_range(0, 3));
      cmd_rs = 2'($urandom_range(0, 3));
      cmd_use_imm = 1'($urandom_range(0, 1));
      cmd_imm = 4'($urandom_range(0, 15));
      ena = ($urandom_range(0, 7) != 0);
      res_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    ena = 1'b1;
    res_ready = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
